// File: rtl/mult_arbiter.sv
// Round-robin front end that shares one shift-add multiplier between NREQ clients:
// grants one operand pair, pulses the multiplier load, waits for done (with watchdog), returns a tagged product.
module mult_arbiter #(
    parameter  int NREQ    = 2,
    parameter  int WIDTH   = 8,
    parameter  int TIMEOUT = 64,
    localparam int ID_W    = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CNT_W   = $clog2(TIMEOUT)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [2*WIDTH-1:0]      resp_prod,
    output logic                    resp_err,
    output logic                    mul_load,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    input  logic                    mul_done,
    input  logic [2*WIDTH-1:0]      mul_prod
);

    typedef enum logic [1:0] {IDLE, LOAD, BUSY, RESP} state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  busy_cnt;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    logic              accept;
    logic [ID_W-1:0]   next_ptr;

    // Rotating priority scan: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        int j;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!grant_found && req_valid[ID_W'(j)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(j);
            end
        end
    end

    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ID_W'(i) == grant_idx) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
                req_ready[i] = grant_found && (state == IDLE) && !reset;
            end
        end
    end

    assign accept   = |(req_valid & req_ready);
    assign next_ptr = (int'(resp_id) == NREQ - 1) ? '0 : resp_id + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            busy_cnt   <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_load   <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_prod  <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mul_a    <= sel_a;
                        mul_b    <= sel_b;
                        resp_id  <= grant_idx;
                        mul_load <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    mul_load <= 1'b0;
                    busy_cnt <= '0;
                    state    <= BUSY;
                end
                BUSY: begin
                    if (busy_cnt != '1) busy_cnt <= busy_cnt + 1'b1;
                    // A done arriving in the watchdog's last cycle still wins.
                    if (mul_done) begin
                        resp_prod  <= mul_prod;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (busy_cnt == CNT_W'(TIMEOUT - 1)) begin
                        resp_prod  <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        rr_ptr     <= next_ptr;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural multiplier whose done latency is programmable.
module tb_mult_arbiter;
    localparam int NREQ = 2, WIDTH = 8, TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [15:0] req_a, req_b;
    logic [1:0]  req_ready;
    logic        resp_valid, resp_ready;
    logic [0:0]  resp_id;
    logic [15:0] resp_prod;
    logic        resp_err;
    logic        mul_load;
    logic [7:0]  mul_a, mul_b;
    logic        mul_done;
    logic [15:0] mul_prod;

    int total = 0;
    int bad   = 0;
    int done_dly = 8;
    int mcnt;
    logic [15:0] pa;

    mult_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_prod(resp_prod), .resp_err(resp_err),
        .mul_load(mul_load), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_prod(mul_prod)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: done becomes visible done_dly cycles after the load cycle; 0 means never.
    always @(posedge clk) begin
        if (reset) begin
            mul_done <= 1'b0;
            mcnt     <= 0;
            mul_prod <= '0;
            pa       <= '0;
        end else begin
            mul_done <= 1'b0;
            if (mul_load) begin
                pa <= {8'b0, mul_a} * {8'b0, mul_b};
                if (done_dly == 1) begin
                    mul_done <= 1'b1;
                    mul_prod <= {8'b0, mul_a} * {8'b0, mul_b};
                end else begin
                    mcnt <= done_dly - 1;
                end
            end else if (mcnt > 0) begin
                mcnt <= mcnt - 1;
                if (mcnt == 1) begin
                    mul_done <= 1'b1;
                    mul_prod <= pa;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Starts in the grant cycle (cycle 0); returns at the negedge of the cycle resp_valid is first seen.
    task automatic run_txn(input string tag, input int id, input logic keep,
                           input int exp_prod, input logic exp_err, input int exp_lat);
        int n;
        @(negedge clk);
        chk({tag, ".grant"}, 32'(req_ready), 32'(1 << id));
        cyc();
        if (!keep) req_valid[id] = 1'b0;
        n = 1;
        @(negedge clk);
        chk({tag, ".load"}, 32'(mul_load), 32'd1);
        while (!resp_valid && n < 200) begin
            cyc();
            n++;
            @(negedge clk);
        end
        chk({tag, ".lat"},  32'(n), 32'(exp_lat));
        chk({tag, ".id"},   32'(resp_id), 32'(id));
        chk({tag, ".prod"}, 32'(resp_prod), 32'(exp_prod));
        chk({tag, ".err"},  32'(resp_err), 32'(exp_err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 2'b01;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        cyc();
        @(negedge clk);
        chk("rst.ready", 32'(req_ready), 32'd0);
        chk("rst.rvalid", 32'(resp_valid), 32'd0);
        chk("rst.load", 32'(mul_load), 32'd0);
        chk("rst.mula", 32'(mul_a), 32'd0);
        chk("rst.prod", 32'(resp_prod), 32'd0);
        cyc();

        // Single request: 13 * 11, done 8 cycles after load
        reset     = 1'b0;
        req_valid = 2'b01;
        req_a     = {8'd0, 8'd13};
        req_b     = {8'd0, 8'd11};
        done_dly  = 8;
        run_txn("single", 0, 1'b0, 143, 1'b0, 10);
        chk("single.mula", 32'(mul_a), 32'd13);
        chk("single.mulb", 32'(mul_b), 32'd11);
        cyc();

        // Simultaneous requests after reset, then alternating fairness
        reset = 1'b1;
        cyc();
        reset     = 1'b0;
        req_valid = 2'b11;
        req_a     = {8'd7, 8'd3};
        req_b     = {8'd9, 8'd5};
        for (int t = 0; t < 6; t++) begin
            run_txn("fair", t % 2, 1'b1, (t % 2) ? 63 : 15, 1'b0, 10);
            cyc();
        end

        // Timeout, no done at all
        req_valid = 2'b01;
        req_a     = {8'd7, 8'd200};
        req_b     = {8'd9, 8'd100};
        done_dly  = 0;
        run_txn("tmo", 0, 1'b0, 0, 1'b1, 66);
        cyc();

        // Minimum latency good request after the timeout
        req_valid = 2'b01;
        req_a     = {8'd7, 8'd255};
        req_b     = {8'd9, 8'd255};
        done_dly  = 1;
        run_txn("min", 0, 1'b0, 65025, 1'b0, 3);
        cyc();

        // Done in the last BUSY cycle beats the watchdog
        req_valid = 2'b10;
        req_a     = {8'd16, 8'd255};
        req_b     = {8'd16, 8'd255};
        done_dly  = 64;
        run_txn("last", 1, 1'b0, 256, 1'b0, 66);
        cyc();

        // Backpressure held for 20 cycles
        resp_ready = 1'b0;
        req_valid  = 2'b01;
        req_a      = {8'd16, 8'd12};
        req_b      = {8'd16, 8'd12};
        done_dly   = 8;
        run_txn("bp", 0, 1'b0, 144, 1'b0, 10);
        for (int t = 0; t < 20; t++) begin
            cyc();
            req_valid = 2'b11;
            @(negedge clk);
            chk("bp.rvalid", 32'(resp_valid), 32'd1);
            chk("bp.prod", 32'(resp_prod), 32'd144);
            chk("bp.id", 32'(resp_id), 32'd0);
            chk("bp.err", 32'(resp_err), 32'd0);
            chk("bp.ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        cyc();
        @(negedge clk);
        chk("bp.after", 32'(resp_valid), 32'd0);
        chk("bp.next_grant", 32'(req_ready), 32'b10);

        // Reset during BUSY: requester 1 accepted, reset in cycle 4
        cyc();
        req_valid = 2'b00;
        @(negedge clk);
        chk("mid.load", 32'(mul_load), 32'd1);
        cyc();
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("mid.mula", 32'(mul_a), 32'd0);
        chk("mid.mulb", 32'(mul_b), 32'd0);
        chk("mid.rvalid", 32'(resp_valid), 32'd0);
        chk("mid.prod", 32'(resp_prod), 32'd0);
        chk("mid.id", 32'(resp_id), 32'd0);
        chk("mid.err", 32'(resp_err), 32'd0);
        chk("mid.load0", 32'(mul_load), 32'd0);
        for (int t = 0; t < 10; t++) begin
            cyc();
            @(negedge clk);
            chk("mid.noresp", 32'(resp_valid), 32'd0);
        end
        cyc();
        req_valid = 2'b11;
        req_a     = {8'd16, 8'd3};
        req_b     = {8'd16, 8'd5};
        run_txn("mid.new", 0, 1'b0, 15, 1'b0, 10);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
